a2d_conv_sched: RTL
===================

# a2d_conv_sched

Round-robin conversion scheduler that owns the SPI master in front of the A2D converter. Each `nxt` request runs one two-transaction conversion: command, then read-back. The channel rotates left load cell → right load cell → battery. Results land in holding registers that feed `steer_en_SM` (load cells) and the battery monitor.

## Interface
- `LFT_CHNL`, default 3'd0: A2D channel of the left load cell.
- `RGHT_CHNL`, default 3'd4: A2D channel of the right load cell.
- `BATT_CHNL`, default 3'd5: A2D channel of the battery divider.
- `clk` in, 1: system clock, 50 MHz.
- `rst_n` in, 1: asynchronous active-low reset.
- `nxt` in, 1: request one conversion of the current channel. Single-cycle pulse from the inertial interface.
- `done` in, 1: SPI master transaction complete. Single-cycle pulse.
- `rd_data` in, 16: SPI MISO word, valid while `done` is high.
- `wrt` out, 1: start an SPI transaction. Registered, single-cycle pulse.
- `cmd` out, 16: SPI MOSI word. Registered, held stable from `wrt` until `done`.
- `lft_ld`, `rght_ld`, `batt` out, 12 each: latest conversion results.
- `conv_done` out, 1: single-cycle pulse when a result register has updated.
- `busy` out, 1: high from the cycle after `nxt` is accepted through the cycle `conv_done` is high.

## Operation
- Command word: `{2'b00, chnl[2:0], 11'h000}`.
- The second (read) transaction resends the same `cmd`. Only the reply matters.
- Round-robin index `rr` is 2 bits. Encoding: 0 = lft, 1 = rght, 2 = batt. Increments after each completed conversion, wrapping 2→0. Value 3 is illegal and forces `rr` to 0.
- States:
  - IDLE → CMD when `nxt`. Pulse `wrt`, load `cmd` for `rr`.
  - CMD → PAUSE when `done`.
  - PAUSE → READ unconditionally after one cycle. Pulse `wrt`. This gap gives the A2D its conversion turnaround.
  - READ → IDLE when `done`. Capture `rd_data[11:0]` into the register selected by `rr`, pulse `conv_done`, advance `rr`.
- `nxt` outside IDLE is ignored. It is not queued.
- `done` in IDLE or PAUSE is ignored.
- Results are unsigned 12-bit values. `rd_data[15:12]` is discarded.
- Registers not selected by `rr` hold their value.

## Timing
- Reset values:
  - State IDLE, `rr` = 0.
  - `wrt` = 0, `cmd` = 16'h0000.
  - `lft_ld` = `rght_ld` = `batt` = 12'h000.
  - `conv_done` = 0, `busy` = 0.
- `nxt` sampled at edge N: `wrt` and the new `cmd` are visible in cycle N+1.
- First `done` at edge D: second `wrt` in cycle D+2 (one PAUSE cycle).
- Second `done` at edge E: result register and `conv_done` visible in cycle E+1. State is IDLE in E+1.
- `nxt` in cycle E+1 is accepted.
- Minimum spacing between first `wrt` and second `wrt` = SPI transaction length + 2 cycles.
- `nxt` and `done` in the same cycle in IDLE: `nxt` wins, `done` is ignored.
- Reset mid-conversion:
  - All outputs and `rr` return to reset values immediately (async).
  - Partial transaction is abandoned.
  - The SPI master is reset by the same `rst_n`.
- No timeout. A missing `done` hangs the block until reset. This is accepted because the SPI master always completes.

## Structure
- Shared package `segway_pkg`:
  - `a2d_state_t` enum {IDLE, CMD, PAUSE, READ}, 2 bits.
  - `rr_idx_t` constants `RR_LFT` = 0, `RR_RGHT` = 1, `RR_BATT` = 2.
  - Default channel localparams.
- Single module. State register plus combinational next-state/output logic.
- Registered `wrt`/`cmd`/result/`conv_done` flops.
- No sub-module. The SPI master is instantiated alongside at the top level, not inside.

## Test plan
- **Reset:** `rst_n` low → all outputs 0, `rr` = 0. First `nxt` after release → `cmd` = 16'h0000 (LFT_CHNL 0), `wrt` one cycle.
- **Rotation:** three conversions with model replies 16'h0ABC, 16'h0123, 16'h0FFF →
  - `lft_ld` = 12'hABC, `rght_ld` = 12'h123, `batt` = 12'hFFF.
  - `cmd` sequence 16'h0000, 16'h2000, 16'h2800.
  - Fourth `nxt` issues 16'h0000 again (wrap).
- **Handshake timing:** SPI model `done` 32 cycles after `wrt` →
  - Second `wrt` exactly 2 cycles after first `done`.
  - `conv_done` exactly 1 cycle after second `done`.
  - `busy` high throughout.
- **Ignored requests:**
  - `nxt` pulses during CMD, PAUSE and READ → single conversion only, `rr` advances by 1.
  - Stray `done` in IDLE → no state change.
- **Upper-bit masking:** reply 16'hF555 → result 12'h555.
- **Reset mid-READ:** assert `rst_n` low → results cleared, `rr` = 0. Next `nxt` converts LFT.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared types and defaults for the segway control blocks.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        PAUSE = 2'd2,
        READ  = 2'd3
    } a2d_state_t;

    typedef logic [1:0] rr_idx_t;

    localparam rr_idx_t RR_LFT  = 2'd0;
    localparam rr_idx_t RR_RGHT = 2'd1;
    localparam rr_idx_t RR_BATT = 2'd2;

    localparam logic [2:0] LFT_CHNL_DEF  = 3'd0;
    localparam logic [2:0] RGHT_CHNL_DEF = 3'd4;
    localparam logic [2:0] BATT_CHNL_DEF = 3'd5;

    function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_conv_sched.sv
// Round-robin A2D conversion scheduler driving the SPI master:
// command transaction, one-cycle pause, then read-back transaction.
module a2d_conv_sched
    import segway_pkg::*;
#(
    parameter logic [2:0] LFT_CHNL  = LFT_CHNL_DEF,
    parameter logic [2:0] RGHT_CHNL = RGHT_CHNL_DEF,
    parameter logic [2:0] BATT_CHNL = BATT_CHNL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        conv_done,
    output logic        busy
);

    a2d_state_t  state_q, state_d;
    rr_idx_t     rr_q, rr_d, rr_cur;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic [11:0] batt_q, batt_d;
    logic        cdone_q, cdone_d;
    logic [2:0]  chnl;

    // An illegal index (3) is treated as the left load cell.
    assign rr_cur = (rr_q == 2'd3) ? RR_LFT : rr_q;

    always_comb begin
        chnl = LFT_CHNL;
        if (rr_cur == RR_RGHT) chnl = RGHT_CHNL;
        if (rr_cur == RR_BATT) chnl = BATT_CHNL;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_cur;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        cdone_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (nxt) begin
                    state_d = CMD;
                    wrt_d   = 1'b1;
                    cmd_d   = a2d_cmd(chnl);
                end
            end
            CMD: begin
                if (done) state_d = PAUSE;
            end
            PAUSE: begin
                state_d = READ;
                wrt_d   = 1'b1;
            end
            READ: begin
                if (done) begin
                    state_d = IDLE;
                    cdone_d = 1'b1;
                    if (rr_cur == RR_LFT)  lft_d  = rd_data[11:0];
                    if (rr_cur == RR_RGHT) rght_d = rd_data[11:0];
                    if (rr_cur == RR_BATT) batt_d = rd_data[11:0];
                    rr_d = (rr_cur == RR_BATT) ? RR_LFT : rr_cur + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= RR_LFT;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'h000;
            cdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
            cdone_q <= cdone_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign conv_done = cdone_q;
    // Stays high through the conv_done cycle, after state is back in IDLE.
    assign busy      = (state_q != IDLE) || cdone_q;

endmodule
